// File: rtl/dc_pred_pkg.sv
// Shared types and constants for the DC intra-prediction sequencer.
package dc_pred_pkg;

  localparam int unsigned DC_BIT_DEPTH   = 8;
  localparam int unsigned DC_MAX_PU_LOG2 = 3;
  localparam int unsigned DC_ACC_W       = 15;

  localparam logic [2:0] PU_4  = 3'd0;
  localparam logic [2:0] PU_8  = 3'd1;
  localparam logic [2:0] PU_16 = 3'd2;
  localparam logic [2:0] PU_32 = 3'd3;

  localparam logic [DC_BIT_DEPTH-1:0] DC_MID = {1'b1, {(DC_BIT_DEPTH-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_T,
    ST_FETCH_L,
    ST_CALC,
    ST_EMIT,
    ST_DONE
  } state_e;

  // Oversized PU codes saturate to the largest supported size.
  function automatic logic [2:0] clamp_pu(input logic [2:0] code, input logic [2:0] max_code);
    return (code > max_code) ? max_code : code;
  endfunction

endpackage

// File: rtl/dc_pred_ctrl_if.sv
// Reference-fetch and sub-block descriptor buses of the DC sequencer.
interface dc_pred_ctrl_if
  import dc_pred_pkg::*;
#(
  parameter int unsigned BIT_DEPTH = DC_BIT_DEPTH
);
  logic                   ref_rd;
  logic                   ref_side;
  logic [2:0]             ref_idx;
  logic                   ref_ack;
  logic [4*BIT_DEPTH-1:0] ref_data;

  logic                   blk_valid;
  logic                   blk_ready;
  logic [2:0]             blk_x;
  logic [2:0]             blk_y;
  logic                   blk_edge_t;
  logic                   blk_edge_l;

  modport master (
    output ref_rd, ref_side, ref_idx,
    input  ref_ack, ref_data,
    output blk_valid, blk_x, blk_y, blk_edge_t, blk_edge_l,
    input  blk_ready
  );

  modport slave (
    input  ref_rd, ref_side, ref_idx,
    output ref_ack, ref_data,
    input  blk_valid, blk_x, blk_y, blk_edge_t, blk_edge_l,
    output blk_ready
  );
endinterface

// File: rtl/dc_pred_acc.sv
// Reference-sample accumulator with registered rounding/shift to the DC value.
module dc_pred_acc
  import dc_pred_pkg::*;
#(
  parameter int unsigned BIT_DEPTH = DC_BIT_DEPTH,
  parameter int unsigned ACC_W     = DC_ACC_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   add_en,
  input  logic                   calc,
  input  logic [2:0]             pu,
  input  logic [1:0]             side_mask,
  input  logic [4*BIT_DEPTH-1:0] ref_data,
  output logic [BIT_DEPTH-1:0]   dc_val
);
  localparam logic [BIT_DEPTH-1:0] MID = {1'b1, {(BIT_DEPTH-1){1'b0}}};

  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     sum01, sum23, grp_sum;
  logic [ACC_W-1:0]     rnd;
  logic [BIT_DEPTH-1:0] dc_next;

  // Two-level adder tree over the four samples of one group.
  assign sum01   = ACC_W'(ref_data[0*BIT_DEPTH +: BIT_DEPTH]) + ACC_W'(ref_data[1*BIT_DEPTH +: BIT_DEPTH]);
  assign sum23   = ACC_W'(ref_data[2*BIT_DEPTH +: BIT_DEPTH]) + ACC_W'(ref_data[3*BIT_DEPTH +: BIT_DEPTH]);
  assign grp_sum = sum01 + sum23;

  // side_mask = {left, top}; one side averages N samples, both sides 2N.
  always_comb begin
    rnd     = '0;
    dc_next = MID;
    case (side_mask)
      2'b11: begin
        rnd     = acc + (ACC_W'(4) << pu);
        dc_next = BIT_DEPTH'(rnd >> (pu + 3'd3));
      end
      2'b01, 2'b10: begin
        rnd     = acc + (ACC_W'(2) << pu);
        dc_next = BIT_DEPTH'(rnd >> (pu + 3'd2));
      end
      default: dc_next = MID;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      dc_val <= '0;
    end else begin
      if (clr)         acc <= '0;
      else if (add_en) acc <= acc + grp_sum;
      if (calc)        dc_val <= dc_next;
    end
  end

endmodule

// File: rtl/dc_pred_ctrl.sv
// DC intra-prediction sequencer: reference fetch, DC calculation, 4x4 sub-block walk.
// Optional edge-filter flags are enabled by defining DC_EDGE_FILT_EN.
module dc_pred_ctrl
  import dc_pred_pkg::*;
#(
  parameter int unsigned BIT_DEPTH   = DC_BIT_DEPTH,
  parameter int unsigned MAX_PU_LOG2 = DC_MAX_PU_LOG2,
  parameter int unsigned ACC_W       = DC_ACC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           pu,
  input  logic                 left_valid,
  input  logic                 top_valid,
  output logic                 busy,
  output logic                 done,
  output logic [BIT_DEPTH-1:0] dc_val,
  dc_pred_ctrl_if.master       bus
);
  localparam logic [2:0] MAX_PU = 3'(MAX_PU_LOG2);

  state_e     state, state_d;
  logic [2:0] pu_q, pu_d;
  logic       top_q, top_d, left_q, left_d;
  logic       busy_d, done_d;
  logic       ref_rd, ref_rd_d, ref_side, ref_side_d;
  logic [2:0] ref_idx, ref_idx_d;
  logic       blk_valid, blk_valid_d;
  logic [2:0] blk_x, blk_x_d, blk_y, blk_y_d;
  logic       edge_t, edge_t_d, edge_l, edge_l_d;
  logic       acc_clr, acc_add, acc_calc;
  logic [2:0] last_idx;

  // Groups per side and blocks per row/column are both 1<<PU.
  assign last_idx = 3'((4'd1 << pu_q) - 4'd1);

  always_comb begin
    state_d     = state;
    pu_d        = pu_q;
    top_d       = top_q;
    left_d      = left_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    ref_rd_d    = ref_rd;
    ref_side_d  = ref_side;
    ref_idx_d   = ref_idx;
    blk_valid_d = blk_valid;
    blk_x_d     = blk_x;
    blk_y_d     = blk_y;
    edge_t_d    = 1'b0;
    edge_l_d    = 1'b0;
    acc_clr     = 1'b0;
    acc_add     = 1'b0;
    acc_calc    = 1'b0;

    case (state)
      ST_IDLE: if (start) begin
        pu_d      = clamp_pu(pu, MAX_PU);
        top_d     = top_valid;
        left_d    = left_valid;
        acc_clr   = 1'b1;
        ref_idx_d = '0;
        if (top_valid) begin
          state_d    = ST_FETCH_T;
          ref_rd_d   = 1'b1;
          ref_side_d = 1'b0;
        end else if (left_valid) begin
          state_d    = ST_FETCH_L;
          ref_rd_d   = 1'b1;
          ref_side_d = 1'b1;
        end else begin
          state_d    = ST_CALC;
        end
      end
      ST_FETCH_T: if (ref_rd && bus.ref_ack) begin
        acc_add = 1'b1;
        if (ref_idx == last_idx) begin
          ref_idx_d = '0;
          if (left_q) begin
            state_d    = ST_FETCH_L;
            ref_side_d = 1'b1;
          end else begin
            state_d  = ST_CALC;
            ref_rd_d = 1'b0;
          end
        end else begin
          ref_idx_d = ref_idx + 3'd1;
        end
      end
      ST_FETCH_L: if (ref_rd && bus.ref_ack) begin
        acc_add = 1'b1;
        if (ref_idx == last_idx) begin
          state_d    = ST_CALC;
          ref_rd_d   = 1'b0;
          ref_side_d = 1'b0;
          ref_idx_d  = '0;
        end else begin
          ref_idx_d = ref_idx + 3'd1;
        end
      end
      ST_CALC: begin
        acc_calc    = 1'b1;
        state_d     = ST_EMIT;
        blk_valid_d = 1'b1;
        blk_x_d     = '0;
        blk_y_d     = '0;
      end
      // Raster walk, X fastest; advances only on a completed handshake.
      ST_EMIT: if (blk_valid && bus.blk_ready) begin
        if (blk_x == last_idx) begin
          blk_x_d = '0;
          if (blk_y == last_idx) begin
            state_d     = ST_DONE;
            blk_valid_d = 1'b0;
            blk_y_d     = '0;
            done_d      = 1'b1;
          end else begin
            blk_y_d = blk_y + 3'd1;
          end
        end else begin
          blk_x_d = blk_x + 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);

`ifdef DC_EDGE_FILT_EN
    edge_t_d = blk_valid_d & top_q  & (blk_y_d == 3'd0) & (pu_q < PU_32);
    edge_l_d = blk_valid_d & left_q & (blk_x_d == 3'd0) & (pu_q < PU_32);
`else
    edge_t_d = 1'b0;
    edge_l_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pu_q      <= '0;
      top_q     <= 1'b0;
      left_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ref_rd    <= 1'b0;
      ref_side  <= 1'b0;
      ref_idx   <= '0;
      blk_valid <= 1'b0;
      blk_x     <= '0;
      blk_y     <= '0;
      edge_t    <= 1'b0;
      edge_l    <= 1'b0;
    end else begin
      state     <= state_d;
      pu_q      <= pu_d;
      top_q     <= top_d;
      left_q    <= left_d;
      busy      <= busy_d;
      done      <= done_d;
      ref_rd    <= ref_rd_d;
      ref_side  <= ref_side_d;
      ref_idx   <= ref_idx_d;
      blk_valid <= blk_valid_d;
      blk_x     <= blk_x_d;
      blk_y     <= blk_y_d;
      edge_t    <= edge_t_d;
      edge_l    <= edge_l_d;
    end
  end

  assign bus.ref_rd     = ref_rd;
  assign bus.ref_side   = ref_side;
  assign bus.ref_idx    = ref_idx;
  assign bus.blk_valid  = blk_valid;
  assign bus.blk_x      = blk_x;
  assign bus.blk_y      = blk_y;
  assign bus.blk_edge_t = edge_t;
  assign bus.blk_edge_l = edge_l;

  dc_pred_acc #(
    .BIT_DEPTH (BIT_DEPTH),
    .ACC_W     (ACC_W)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .clr       (acc_clr),
    .add_en    (acc_add),
    .calc      (acc_calc),
    .pu        (pu_q),
    .side_mask ({left_q, top_q}),
    .ref_data  (bus.ref_data),
    .dc_val    (dc_val)
  );

endmodule
